// File: rtl/button_gesture_decoder_pkg.sv
// Shared types for the front-panel button gesture decoder: gesture codes,
// decoder FSM states and a small sizing helper.
package gesture_pkg;

  typedef enum logic [1:0] {
    G_NONE   = 2'd0,
    G_SINGLE = 2'd1,
    G_DOUBLE = 2'd2,
    G_LONG   = 2'd3
  } gesture_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_gesture_decoder_debounce.sv
// Two-flop synchroniser and debounce counter for the active-low push button;
// pressed toggles after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clock,
  input  logic nReset,
  input  logic button,
  output logic pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_pressed;
  logic [CW-1:0] r_count;
  logic          w_level;

  // Synchroniser idles at 1 so a released button looks released out of reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
    end else begin
      r_sync0 <= button;
      r_sync1 <= r_sync0;
    end
  end

  assign w_level = ~r_sync1;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_count   <= '0;
      r_pressed <= 1'b0;
    end else if (w_level != r_pressed) begin
      if (r_count == CNT_LIM) begin
        r_pressed <= ~r_pressed;
        r_count   <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else begin
      r_count <= '0;
    end
  end

  assign pressed = r_pressed;

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced button presses into SINGLE / DOUBLE / LONG gestures.
// Define GESTURE_REPEAT_EN to re-emit G_LONG every REPEAT_CYCLES while held.
module button_gesture_decoder
  import gesture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int GAP_CYCLES      = 12500000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       button,
  output logic       pressed,
  output logic [1:0] gesture,
  output logic       gesture_valid
);

  localparam int TW = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [TW-1:0] LONG_LIM = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LIM  = TW'(GAP_CYCLES - 1);

  logic          w_pressed;
  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_timer;
  logic          w_timer_clr;
  logic          w_rep_clr;
  logic          w_long_hit;
  logic          w_gap_hit;
  logic          w_emit;
  gesture_t      w_emit_code;
  gesture_t      r_gesture;
  logic          r_valid;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clock  (Clock),
    .nReset (nReset),
    .button (button),
    .pressed(w_pressed)
  );

  assign w_long_hit = (r_timer == LONG_LIM);
  assign w_gap_hit  = (r_timer == GAP_LIM);

`ifdef GESTURE_REPEAT_EN
  localparam logic [TW-1:0] REP_LIM = TW'(REPEAT_CYCLES - 1);

  // Only a HOLD reached from a long first press auto-repeats.
  logic r_rep_hold;
  logic w_rep_hold_next;
  logic w_rep_hit;

  assign w_rep_hit = (r_timer == REP_LIM);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_rep_hold <= 1'b0;
    else         r_rep_hold <= w_rep_hold_next;
  end
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Each state implies the level it waits to leave, so a level test is an edge
  // test; the level check comes first so release/press wins over a timer limit.
  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_emit_code  = G_NONE;
    w_rep_clr    = 1'b0;
`ifdef GESTURE_REPEAT_EN
    w_rep_hold_next = r_rep_hold;
`endif
    case (r_state)
      IDLE: begin
        if (w_pressed) w_state_next = PRESS1;
      end
      PRESS1: begin
        if (!w_pressed) begin
          w_state_next = WAIT2;
        end else if (w_long_hit) begin
          w_state_next = HOLD;
          w_emit       = 1'b1;
          w_emit_code  = G_LONG;
`ifdef GESTURE_REPEAT_EN
          w_rep_hold_next = 1'b1;
`endif
        end
      end
      WAIT2: begin
        if (w_pressed) begin
          w_state_next = PRESS2;
        end else if (w_gap_hit) begin
          w_state_next = IDLE;
          w_emit       = 1'b1;
          w_emit_code  = G_SINGLE;
        end
      end
      PRESS2: begin
        if (!w_pressed) begin
          w_state_next = IDLE;
          w_emit       = 1'b1;
          w_emit_code  = G_DOUBLE;
        end else if (w_long_hit) begin
          w_state_next = HOLD;
          w_emit       = 1'b1;
          w_emit_code  = G_DOUBLE;
`ifdef GESTURE_REPEAT_EN
          w_rep_hold_next = 1'b0;
`endif
        end
      end
      HOLD: begin
        if (!w_pressed) begin
          w_state_next = IDLE;
        end else begin
`ifdef GESTURE_REPEAT_EN
          if (r_rep_hold && w_rep_hit) begin
            w_emit      = 1'b1;
            w_emit_code = G_LONG;
            w_rep_clr   = 1'b1;
          end
`endif
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_timer_clr = (w_state_next != r_state) || w_rep_clr;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)                r_timer <= '0;
    else if (w_timer_clr)       r_timer <= '0;
    else if (r_timer != '1)     r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_gesture <= G_NONE;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) r_gesture <= w_emit_code;
    end
  end

  assign pressed       = w_pressed;
  assign gesture       = r_gesture;
  assign gesture_valid = r_valid;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scoreboard bench for button_gesture_decoder: stimulus pushes expected pressed
// edges and gesture events; a negedge monitor pops and compares them.
module tb_button_gesture_decoder;
  import gesture_pkg::*;

  localparam int DB  = 2;
  localparam int LC  = 8;
  localparam int GC  = 6;
  localparam int RC  = 4;
  localparam int LAT = 2 + DB;

  logic       Clock  = 1'b0;
  logic       nReset = 1'b1;
  logic       button = 1'b1;
  logic       pressed;
  logic [1:0] gesture;
  logic       gesture_valid;

  button_gesture_decoder #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .GAP_CYCLES     (GC),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .button       (button),
    .pressed      (pressed),
    .gesture      (gesture),
    .gesture_valid(gesture_valid)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int at;
    int val;
  } exp_t;

  exp_t q_gest[$];
  exp_t q_pr[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  logic prev_pressed = 1'b0;
  logic prev_valid   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic push_g(input int at, input int code);
    q_gest.push_back('{at, code});
  endtask

  task automatic push_p(input int at, input int val);
    q_pr.push_back('{at, val});
  endtask

  // Press for 4 cycles then release: SINGLE once the gap expires.
  task automatic do_single();
    int c0;
    int f;
    c0 = cyc;
    button = 1'b0;
    push_p(c0 + LAT, 1);
    wait_cyc(4);
    button = 1'b1;
    f = c0 + 4 + LAT;
    push_p(f, 0);
    push_g(f + GC + 1, G_SINGLE);
  endtask

  always @(negedge Clock) begin
    if (mon_en) begin
      if (!nReset) begin
        check("rst_pressed", pressed, 0);
        check("rst_gesture", gesture, 0);
        check("rst_valid", gesture_valid, 0);
      end else begin
        if (pressed !== prev_pressed) begin
          if (q_pr.size() == 0) begin
            check("unexp_pressed", pressed, prev_pressed);
          end else begin
            mon_e = q_pr.pop_front();
            check("pressed_cyc", cyc, mon_e.at);
            check("pressed_val", pressed, mon_e.val);
          end
        end
        if (gesture_valid) begin
          if (prev_valid) check("valid_b2b", gesture_valid, 0);
          if (q_gest.size() == 0) begin
            check("unexp_valid", gesture_valid, 0);
          end else begin
            mon_e = q_gest.pop_front();
            $display("cycle %0d: gesture %0d (expected %0d at cycle %0d)", cyc, gesture, mon_e.val, mon_e.at);
            check("gest_cyc", cyc, mon_e.at);
            check("gest_code", gesture, mon_e.val);
          end
        end
      end
      prev_pressed = pressed;
      prev_valid   = gesture_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int r;
    int f;

    // Reset with the button released.
    #1 nReset = 1'b0;
    mon_en = 1'b1;
    wait_cyc(3);
    nReset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_cyc(1);
      check("post_rst_pressed", pressed, 0);
      check("post_rst_gesture", gesture, G_NONE);
      check("post_rst_valid", gesture_valid, 0);
    end

    // Single press.
    do_single();
    wait_cyc(25);

    // Double press: low 4, high 3, low 4, high.
    c0 = cyc;
    button = 1'b0;
    push_p(c0 + LAT, 1);
    wait_cyc(4);
    button = 1'b1;
    push_p(c0 + 4 + LAT, 0);
    wait_cyc(3);
    button = 1'b0;
    push_p(c0 + 7 + LAT, 1);
    wait_cyc(4);
    button = 1'b1;
    f = c0 + 11 + LAT;
    push_p(f, 0);
    push_g(f + 1, G_DOUBLE);
    wait_cyc(25);

    // Long press: low 20 cycles.
    c0 = cyc;
    button = 1'b0;
    r = c0 + LAT;
    f = c0 + 20 + LAT;
    push_p(r, 1);
    push_g(r + LC + 1, G_LONG);
`ifdef GESTURE_REPEAT_EN
    for (int t = r + LC + 1 + RC; t <= f; t += RC) push_g(t, G_LONG);
`endif
    wait_cyc(20);
    button = 1'b1;
    push_p(f, 0);
    wait_cyc(20);

    // One-cycle glitch: nothing changes.
    button = 1'b0;
    wait_cyc(1);
    button = 1'b1;
    wait_cyc(15);
    check("glitch_pressed", pressed, 0);

    // Reset while waiting for a second press: partial gesture is dropped.
    c0 = cyc;
    button = 1'b0;
    push_p(c0 + LAT, 1);
    wait_cyc(4);
    button = 1'b1;
    push_p(c0 + 4 + LAT, 0);
    wait_cyc(6);
    nReset = 1'b0;
    wait_cyc(3);
    nReset = 1'b1;
    wait_cyc(1);
    check("midrst_gesture", gesture, G_NONE);
    check("midrst_valid", gesture_valid, 0);
    wait_cyc(15);
    do_single();
    wait_cyc(25);

    check("sb_gest_pending", q_gest.size(), 0);
    check("sb_pressed_pending", q_pr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
